// File: rtl/seq_unary_reduce.sv
// Serial multi-mode unary reduction engine.
// Reduces an N-bit operand with AND/NAND/OR/NOR/XOR/XNOR, W bits per clock,
// behind valid/ready handshakes on both the input and the result side.
module seq_unary_reduce #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         c,
    output logic         err,
    output logic         busy
);

    localparam int K  = (N + W - 1) / W;       // number of chunks
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = K * W;                 // operand width after padding

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   opnd_q;
    logic [2:0]     op_q;
    logic           acc_q;
    logic [CW-1:0]  cnt_q;
    logic           c_q;
    logic           err_q;

    logic           accept;
    logic           last;
    logic           illegal;
    logic           invert;
    logic           ident_q;
    logic [PW-1:0]  padded;
    logic [PW-1:0]  shifted;
    logic [W-1:0]   chunk;
    logic           chunk_red;
    logic           acc_fold;

    // Identity of the base function: 1 for the AND family (op[2:1]=00) and for
    // the illegal codes (op[2:1]=11), 0 for the OR and XOR families.
    function automatic logic ident_of(input logic [2:0] o);
        return ~(o[2] ^ o[1]);
    endfunction

    // in_ready is gated by rst_n so it reads 0 for as long as reset is held,
    // independent of what the state register held before the first edge.
    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign c         = c_q;
    assign err       = err_q;

    assign illegal = op_q[2] & op_q[1];
    assign invert  = op_q[0] & ~illegal;
    assign ident_q = ident_of(op_q);
    assign last    = (cnt_q == CW'(K - 1));

    // Pad the captured operand to K*W bits with the identity and select chunk k.
    always_comb begin
        padded         = {PW{ident_q}};
        padded[N-1:0]  = opnd_q;
        shifted        = padded >> (int'(cnt_q) * W);
        chunk          = shifted[W-1:0];
    end

    // Reduce the current chunk with the base function and fold it into the accumulator.
    always_comb begin
        chunk_red = &chunk;
        acc_fold  = acc_q & chunk_red;
        case (op_q[2:1])
            2'b01: begin
                chunk_red = |chunk;
                acc_fold  = acc_q | chunk_red;
            end
            2'b10: begin
                chunk_red = ^chunk;
                acc_fold  = acc_q ^ chunk_red;
            end
            default: begin
                chunk_red = &chunk;
                acc_fold  = acc_q & chunk_red;
            end
        endcase
    end

    // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept)    state_d = S_RUN;
            S_RUN:  if (last)      state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // Control state, accumulator, chunk counter and result registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        acc_q <= ident_of(op);
                        cnt_q <= '0;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_fold;
                    if (last) begin
                        c_q   <= illegal ? 1'b0 : (acc_fold ^ invert);
                        err_q <= illegal;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand and op capture on the accept cycle only.
    always_ff @(posedge clk) begin
        // NOTE: the operand/op registers carry no reset; they are only read after a capture has loaded them.
        if (accept) begin
            opnd_q <= a;
            op_q   <= op;
        end
    end

endmodule

// File: doc/seq_unary_reduce.md
Name: seq_unary_reduce

Overview:
- Multi-mode, parametrised unary reduction engine. Generalises the single-function structural NAND reduction.
- Reduces an N-bit operand with AND, NAND, OR, NOR, XOR or XNOR.
- Processes W bits per clock, so wide operands reduce serially with bounded gate depth.
- Sits behind a valid/ready input port and a valid/ready output port, so it drops into pipelined datapaths in the BasicCombinationalLogic library.

Parameters:
- N, 32, operand width in bits (N >= 1).
- W, 8, chunk width reduced per cycle (1 <= W <= N); K = ceil(N/W) chunks.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept an operand.
- a  input  N  operand A.
- op  input  3  operation select.
- out_valid  output  1  result C valid.
- out_ready  input  1  consumer accepts result.
- c  output  1  result C.
- err  output  1  unsupported op code; qualified by out_valid.
- busy  output  1  state != IDLE.

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Op encoding:
  - 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR.
  - 110 and 111 are illegal.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture a into operand register and op into op register; load accumulator with the identity; clear chunk counter; go to RUN.
  - Identity: 1 for AND/NAND and illegal codes; 0 for OR/NOR/XOR/XNOR.
  - RUN: in_ready=0. Each cycle:
    - Reduce chunk k = bits [k*W+W-1 : k*W] of the captured operand with the base function (AND/OR/XOR), then fold it into the accumulator.
    - Chunk 0 (LSBs) is processed first.
    - In the final chunk, bit positions >= N are padded with the identity.
    - Counter increments. When k = K-1, register c = acc_final XOR invert (invert=1 for NAND/NOR/XNOR), set err, go to DONE.
  - DONE: out_valid=1; c and err held stable. On out_ready, go to IDLE next cycle and clear out_valid.
  - DONE does not accept new input; in_ready=0.
- Latency and throughput:
  - Accept on edge E0 -> out_valid high after edge E_K (K cycles later).
  - Throughput is one operation per K+2 cycles, given out_ready already high.
- Illegal op: K cycles are still consumed; c=0, err=1. All legal ops give err=0.
- Inputs a/op are ignored outside the accept cycle; changes during RUN have no effect.
- in_valid while not in_ready: no capture. The producer must hold until accepted.
- K=1 (W>=N): RUN lasts exactly one cycle.
- Reset:
  - While rst_n=0 at a clock edge: state IDLE, out_valid=0, c=0, err=0, counter=0, accumulator=0.
  - in_ready is 0 while rst_n is low and 1 in the first cycle after release.
  - Reset during RUN or DONE aborts the operation; no result is ever presented for it.
- Counter width: clog2(K), minimum 1 bit. The counter never wraps past K-1.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- N=32, W=8, op=AND, a=0xFFFFFFFF -> out_valid rises exactly 4 cycles after accept; c=1, err=0. Repeat with a=0xFFFF7FFF -> c=0.
- N=32, W=8: NAND a=0xFFFFFFFE -> c=1; NOR a=0x00000000 -> c=1; OR a=0x80000000 -> c=1; XOR a=0x00000007 -> c=1; XNOR a=0x00000007 -> c=0.
- N=12, W=8 (K=2, 4 padded bits): AND a=0xFFF -> c=1; XOR a=0x800 -> c=1; NOR a=0x000 -> c=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> c/out_valid stable, in_ready=0 throughout. Raise out_ready -> in_ready=1 next cycle; a back-to-back second operation gives its correct result.
- op=110, a=any -> out_valid after K cycles with c=0, err=1. Change a and op mid-RUN -> result unaffected.
- Assert rst_n=0 for one cycle at the 2nd RUN cycle -> out_valid never asserts for that operation; in_ready=1 the cycle after release. A new AND of all-ones then gives c=1.
